// File: rtl/env_voice_alloc_if.sv
// Note/voice bus between the sequencer front end, the allocator and the env bank.
// Ports: master = front end + env bank side (drives ena, note events, env_busy),
//        slave  = allocator side (drives ready, triggers, voice state, status pulses).
interface env_voice_alloc_if #(
  parameter int VOICES = 4,
  parameter int NOTE_W = 7
);
  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic                     ena;
  logic                     note_on;
  logic                     note_off;
  logic [NOTE_W-1:0]        note;
  logic [VOICES-1:0]        env_busy;
  logic                     ready;
  logic [VOICES-1:0]        env_trig;
  logic [VOICES-1:0]        voice_gate;
  logic [VOICES*NOTE_W-1:0] voice_note;
  logic [IDX_W-1:0]         alloc_idx;
  logic                     stole;
  logic                     dropped;

  modport master (
    output ena, note_on, note_off, note, env_busy,
    input  ready, env_trig, voice_gate, voice_note, alloc_idx, stole, dropped
  );

  modport slave (
    input  ena, note_on, note_off, note, env_busy,
    output ready, env_trig, voice_gate, voice_note, alloc_idx, stole, dropped
  );
endinterface

// File: rtl/env_voice_alloc.sv
// Voice allocator: picks an env voice per note_on (retrigger > free > steal oldest), fires its trigger.
// Latency: note_on accepted at cycle t -> one-cycle env_trig at t+VOICES+1; ready back high at t+VOICES+2.
// Backpressure: ready low while a scan/fire is in flight; note_on then is dropped (dropped pulse); ena=0 freezes all.
// Ports: clk, rst (sync, active-high), bus (slave modport of env_voice_alloc_if).
module env_voice_alloc #(
  parameter int VOICES = 4,
  parameter int NOTE_W = 7,
  parameter int AGE_W  = 8
) (
  input logic               clk,
  input logic               rst,
  env_voice_alloc_if.slave  bus
);
  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, FIRE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  scanK;
  logic [IDX_W-1:0]  selIdx;
  logic [NOTE_W-1:0] reqNote;
  logic [NOTE_W-1:0] noteQ [VOICES];
  logic [AGE_W-1:0]  age   [VOICES];
  logic [VOICES-1:0] gateQ;
  logic [VOICES-1:0] trigQ;
  logic [IDX_W-1:0]  allocIdxQ;
  logic              readyQ;
  logic              stoleQ;
  logic              droppedQ;

  // Running best candidates accumulated across the scan.
  logic              retrigFound, freeFound;
  logic [IDX_W-1:0]  retrigIdx, freeIdx, stealIdx;
  logic [AGE_W-1:0]  stealAge;

  // Candidates after folding in the voice under scan this cycle.
  logic              retrigFoundN, freeFoundN;
  logic [IDX_W-1:0]  retrigIdxN, freeIdxN, stealIdxN;
  logic [AGE_W-1:0]  stealAgeN;
  logic [IDX_W-1:0]  pickIdx;
  logic              pickSteal;

  always_comb begin
    retrigFoundN = retrigFound;
    retrigIdxN   = retrigIdx;
    freeFoundN   = freeFound;
    freeIdxN     = freeIdx;
    stealIdxN    = stealIdx;
    stealAgeN    = stealAge;
    pickIdx      = '0;
    pickSteal    = 1'b0;

    if (!retrigFound && gateQ[scanK] && (noteQ[scanK] == reqNote)) begin
      retrigFoundN = 1'b1;
      retrigIdxN   = scanK;
    end
    // env_busy is read live, so only the cycle voice k is scanned matters for it.
    if (!freeFound && !bus.env_busy[scanK] && !gateQ[scanK]) begin
      freeFoundN = 1'b1;
      freeIdxN   = scanK;
    end
    // Strict compare keeps the lowest index on equal ages.
    if ((scanK == '0) || (age[scanK] > stealAge)) begin
      stealIdxN = scanK;
      stealAgeN = age[scanK];
    end

    if (retrigFoundN) begin
      pickIdx = retrigIdxN;
    end else if (freeFoundN) begin
      pickIdx = freeIdxN;
    end else begin
      pickIdx   = stealIdxN;
      pickSteal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scanK       <= '0;
      selIdx      <= '0;
      reqNote     <= '0;
      gateQ       <= '0;
      trigQ       <= '0;
      allocIdxQ   <= '0;
      readyQ      <= 1'b1;
      stoleQ      <= 1'b0;
      droppedQ    <= 1'b0;
      retrigFound <= 1'b0;
      freeFound   <= 1'b0;
      retrigIdx   <= '0;
      freeIdx     <= '0;
      stealIdx    <= '0;
      stealAge    <= '0;
      for (int i = 0; i < VOICES; i++) begin
        noteQ[i] <= '0;
        age[i]   <= '0;
      end
    end else if (bus.ena) begin
      trigQ    <= '0;
      stoleQ   <= 1'b0;
      droppedQ <= bus.note_on && !readyQ;

      for (int i = 0; i < VOICES; i++) begin
        if (age[i] != AGE_MAX) age[i] <= age[i] + 1'b1;
        if (bus.note_off && gateQ[i] && (noteQ[i] == bus.note)) gateQ[i] <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.note_on) begin
            reqNote     <= bus.note;
            scanK       <= '0;
            readyQ      <= 1'b0;
            retrigFound <= 1'b0;
            freeFound   <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          retrigFound <= retrigFoundN;
          retrigIdx   <= retrigIdxN;
          freeFound   <= freeFoundN;
          freeIdx     <= freeIdxN;
          stealIdx    <= stealIdxN;
          stealAge    <= stealAgeN;
          if (scanK == LAST_K) begin
            // Trigger register is loaded here so the pulse is visible during FIRE.
            selIdx         <= pickIdx;
            trigQ[pickIdx] <= 1'b1;
            stoleQ         <= pickSteal;
            state          <= FIRE;
          end else begin
            scanK <= scanK + 1'b1;
          end
        end
        FIRE: begin
          // Written after the note_off loop so FIRE wins on the same voice.
          noteQ[selIdx] <= reqNote;
          gateQ[selIdx] <= 1'b1;
          age[selIdx]   <= '0;
          allocIdxQ     <= selIdx;
          readyQ        <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses are masked while frozen so a held register never repeats a pulse.
  assign bus.env_trig   = bus.ena ? trigQ : '0;
  assign bus.stole      = bus.ena & stoleQ;
  assign bus.dropped    = bus.ena & droppedQ;
  assign bus.ready      = readyQ;
  assign bus.voice_gate = gateQ;
  assign bus.alloc_idx  = allocIdxQ;

  for (genvar g = 0; g < VOICES; g++) begin : gNotePack
    assign bus.voice_note[g*NOTE_W +: NOTE_W] = noteQ[g];
  end
endmodule

// File: tb/tb_env_voice_alloc.sv
module tb_env_voice_alloc;
  localparam int VOICES = 4;
  localparam int NOTE_W = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  env_voice_alloc_if #(.VOICES(VOICES), .NOTE_W(NOTE_W)) bus ();

  env_voice_alloc #(.VOICES(VOICES), .NOTE_W(NOTE_W), .AGE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0] busy;
    logic       offVld;
    logic [6:0] offNote;
    logic [6:0] onNote;
    logic [3:0] expTrig;
    logic       expStole;
    logic [1:0] expIdx;
    logic [3:0] expGate;
  } vec_t;

  vec_t       vecs [12];
  logic [6:0] expNotes [VOICES];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] vnote(input int i);
    return bus.voice_note[i*NOTE_W +: NOTE_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    bus.ena      = 1'b1;
    bus.note_on  = 1'b0;
    bus.note_off = 1'b0;
    bus.note     = '0;
    bus.env_busy = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < VOICES; i++) expNotes[i] = '0;
  endtask

  // Waits (bounded) for env_trig; returns cycles waited.
  task automatic waitTrig(output int n);
    n = 0;
    while (bus.env_trig == '0 && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic runVec(input vec_t v, input int n);
    int lat;
    int sel;
    bus.env_busy = v.busy;
    if (v.offVld) begin
      bus.note_off = 1'b1;
      bus.note     = v.offNote;
      tick();
      bus.note_off = 1'b0;
    end
    check($sformatf("v%0d ready_idle", n), 32'(bus.ready), 32'd1);
    bus.note_on = 1'b1;
    bus.note    = v.onNote;
    tick();
    bus.note_on = 1'b0;
    bus.note    = '0;
    check($sformatf("v%0d ready_busy", n), 32'(bus.ready), 32'd0);
    waitTrig(lat);
    lat = lat + 1;
    check($sformatf("v%0d latency", n), 32'(lat), 32'(VOICES + 1));
    check($sformatf("v%0d trig", n), 32'(bus.env_trig), 32'(v.expTrig));
    check($sformatf("v%0d stole", n), 32'(bus.stole), 32'(v.expStole));
    tick();
    check($sformatf("v%0d trig_end", n), 32'(bus.env_trig), 32'd0);
    check($sformatf("v%0d ready_back", n), 32'(bus.ready), 32'd1);
    check($sformatf("v%0d gate", n), 32'(bus.voice_gate), 32'(v.expGate));
    check($sformatf("v%0d alloc_idx", n), 32'(bus.alloc_idx), 32'(v.expIdx));
    sel = 0;
    for (int i = 0; i < VOICES; i++) if (v.expTrig[i]) sel = i;
    expNotes[sel] = v.onNote;
    for (int i = 0; i < VOICES; i++)
      check($sformatf("v%0d note%0d", n, i), 32'(vnote(i)), 32'(expNotes[i]));
  endtask

  initial begin
    int cnt;
    int lat;

    //           busy    off  offNote onNote trig   stole idx   gate
    vecs[0]  = '{4'b0000, 1'b0, 7'd0,  7'd60, 4'b0001, 1'b0, 2'd0, 4'b0001};
    vecs[1]  = '{4'b0000, 1'b0, 7'd0,  7'd62, 4'b0010, 1'b0, 2'd1, 4'b0011};
    vecs[2]  = '{4'b0000, 1'b0, 7'd0,  7'd64, 4'b0100, 1'b0, 2'd2, 4'b0111};
    vecs[3]  = '{4'b0000, 1'b0, 7'd0,  7'd66, 4'b1000, 1'b0, 2'd3, 4'b1111};
    vecs[4]  = '{4'b1111, 1'b0, 7'd0,  7'd67, 4'b0001, 1'b1, 2'd0, 4'b1111}; // steal oldest
    vecs[5]  = '{4'b1111, 1'b0, 7'd0,  7'd62, 4'b0010, 1'b0, 2'd1, 4'b1111}; // retrigger
    vecs[6]  = '{4'b1111, 1'b0, 7'd0,  7'd70, 4'b0100, 1'b1, 2'd2, 4'b1111};
    vecs[7]  = '{4'b0000, 1'b0, 7'd0,  7'd71, 4'b1000, 1'b1, 2'd3, 4'b1111}; // gated idle env still stolen
    vecs[8]  = '{4'b0000, 1'b1, 7'd62, 7'd72, 4'b0010, 1'b0, 2'd1, 4'b1111}; // released voice is free
    vecs[9]  = '{4'b0100, 1'b1, 7'd70, 7'd73, 4'b0001, 1'b1, 2'd0, 4'b1011}; // released but busy: steal
    vecs[10] = '{4'b0000, 1'b0, 7'd0,  7'd74, 4'b0100, 1'b0, 2'd2, 4'b1111};
    vecs[11] = '{4'b0000, 1'b1, 7'd71, 7'd73, 4'b0001, 1'b0, 2'd0, 4'b0111}; // retrigger beats free

    doReset();
    check("rst ready", 32'(bus.ready), 32'd1);
    check("rst trig", 32'(bus.env_trig), 32'd0);
    check("rst gate", 32'(bus.voice_gate), 32'd0);
    check("rst notes", 32'(bus.voice_note), 32'd0);
    check("rst alloc_idx", 32'(bus.alloc_idx), 32'd0);
    check("rst stole", 32'(bus.stole), 32'd0);
    check("rst dropped", 32'(bus.dropped), 32'd0);

    for (int i = 0; i < 12; i++) runVec(vecs[i], i);

    // note_on during the scan is dropped and does not disturb the scan
    doReset();
    bus.note_on = 1'b1;
    bus.note    = 7'd60;
    tick();
    bus.note    = 7'd70;
    tick();
    bus.note_on = 1'b0;
    bus.note    = '0;
    check("drop pulse", 32'(bus.dropped), 32'd1);
    tick();
    check("drop once", 32'(bus.dropped), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.env_trig != '0) cnt++;
    end
    check("drop trig count", 32'(cnt), 32'd1);
    check("drop note0", 32'(vnote(0)), 32'd60);
    check("drop gate", 32'(bus.voice_gate), 32'b0001);

    // note_off in the FIRE cycle loses to FIRE; later note_off releases
    doReset();
    bus.note_on = 1'b1;
    bus.note    = 7'd60;
    tick();
    bus.note_on = 1'b0;
    waitTrig(lat);
    check("fire_off trig", 32'(bus.env_trig), 32'b0001);
    bus.note_off = 1'b1;
    bus.note     = 7'd60;
    tick();
    bus.note_off = 1'b0;
    check("fire_off gate kept", 32'(bus.voice_gate), 32'b0001);
    bus.note_off = 1'b1;
    bus.note     = 7'd61;
    tick();
    check("off nomatch gate", 32'(bus.voice_gate), 32'b0001);
    bus.note = 7'd60;
    tick();
    bus.note_off = 1'b0;
    check("off gate cleared", 32'(bus.voice_gate), 32'b0000);
    check("off note kept", 32'(vnote(0)), 32'd60);
    check("off no trig", 32'(bus.env_trig), 32'd0);

    // reset in the middle of a scan aborts it
    doReset();
    runVec(vecs[0], 100);
    bus.note_on = 1'b1;
    bus.note    = 7'd62;
    tick();
    bus.note_on = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst ready", 32'(bus.ready), 32'd1);
    check("midrst gate", 32'(bus.voice_gate), 32'd0);
    check("midrst note0", 32'(vnote(0)), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.env_trig != '0) cnt++;
      tick();
    end
    check("midrst no trig", 32'(cnt), 32'd0);

    // ena low for 10 cycles mid-scan stretches latency by 10
    doReset();
    bus.note_on = 1'b1;
    bus.note    = 7'd60;
    tick();
    bus.note_on = 1'b0;
    tick();
    bus.ena = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.env_trig != '0 || bus.ready != 1'b0) cnt++;
    end
    check("freeze hold", 32'(cnt), 32'd0);
    bus.ena = 1'b1;
    waitTrig(lat);
    check("freeze latency", 32'(lat + 12), 32'd15);
    check("freeze trig", 32'(bus.env_trig), 32'b0001);
    tick();
    check("freeze gate", 32'(bus.voice_gate), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
